// File: rtl/note_lane_ctrl.sv
// note_lane_ctrl: once-per-frame sequencer for the five note lanes.
// Fetches beat patterns, spawns notes, moves them down the screen, retires
// missed notes, judges button presses against the hit zone and keeps score/combo.
//
// state | meaning
// IDLE  | waiting for frame_tick; button presses are judged here
// FETCH | pat_req raised, waiting for pat_valid from the pattern ROM
// SPAWN | captured pattern spawns notes on free lanes
// MOVE  | active notes advance by SPEED, notes past the window are missed
module note_lane_ctrl #(
    parameter int SPEED       = 2,
    parameter int BEAT_FRAMES = 30,
    parameter int HIT_TOP     = 425,
    parameter int HIT_BOT     = 470,
    parameter int HIT_POINTS  = 10,
    parameter int SCORE_MAX   = 99999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [4:0]  btn,
    output logic        pat_req,
    input  logic        pat_valid,
    input  logic [4:0]  pat_data,
    output logic [4:0]  note_active,
    output logic [49:0] note_y,
    output logic [16:0] score,
    output logic [7:0]  combo,
    output logic        hit_pulse,
    output logic        miss_pulse
);
    localparam int              CW        = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;
    localparam logic [CW-1:0]   BEAT_LAST = CW'(BEAT_FRAMES - 1);
    localparam logic [9:0]      Y_TOP     = 10'(HIT_TOP);
    localparam logic [9:0]      Y_BOT     = 10'(HIT_BOT);
    localparam logic [10:0]     Y_STEP    = 11'(SPEED);
    localparam logic [17:0]     PTS       = 18'(HIT_POINTS);
    localparam logic [17:0]     S_MAX     = 18'(SCORE_MAX);

    typedef enum logic [1:0] {IDLE, FETCH, SPAWN, MOVE} state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic [4:0]    btn_s1, btn_s2, btn_prev;
    logic [4:0]    press, pend, judge, pat_lat;
    logic [4:0]    hit_vec, stray_vec, miss_vec;
    logic [10:0]   y_sum [5];
    logic [9:0]    y_mv [5];
    logic [2:0]    hit_n;
    logic [17:0]   score_sum;
    logic [16:0]   score_next;
    logic [8:0]    combo_sum;
    logic [7:0]    combo_next;

    assign press = btn_s2 & ~btn_prev;
    // presses held back while busy are merged with fresh ones on the first IDLE cycle
    assign judge = press | pend;

    // two-flop synchronizer plus history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    // per-lane move/miss/hit evaluation and saturating score/combo arithmetic
    always_comb begin
        hit_vec   = '0;
        stray_vec = '0;
        miss_vec  = '0;
        hit_n     = '0;
        y_sum     = '{default: '0};
        y_mv      = '{default: '0};
        for (int i = 0; i < 5; i++) begin
            y_sum[i]     = {1'b0, note_y[10*i +: 10]} + Y_STEP;
            y_mv[i]      = y_sum[i][10] ? 10'h3FF : y_sum[i][9:0];
            miss_vec[i]  = note_active[i] && (y_mv[i] > Y_BOT);
            hit_vec[i]   = judge[i] && note_active[i] &&
                           (note_y[10*i +: 10] > Y_TOP) && (note_y[10*i +: 10] <= Y_BOT);
            stray_vec[i] = judge[i] && !hit_vec[i];
            hit_n        = hit_n + {2'b00, hit_vec[i]};
        end
        score_sum  = {1'b0, score} + ({15'd0, hit_n} * PTS);
        score_next = (score_sum > S_MAX) ? S_MAX[16:0] : score_sum[16:0];
        combo_sum  = {1'b0, combo} + {6'd0, hit_n};
        if (|stray_vec)
            combo_next = '0;
        else
            combo_next = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end

    // frame sequencer with registered lane, score and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            pend        <= '0;
            pat_lat     <= '0;
            pat_req     <= 1'b0;
            note_active <= '0;
            note_y      <= '0;
            score       <= '0;
            combo       <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    pend <= '0;
                    // judging comes before the frame decision in the same cycle
                    if (|judge) begin
                        for (int i = 0; i < 5; i++) begin
                            if (hit_vec[i]) begin
                                note_active[i]      <= 1'b0;
                                note_y[10*i +: 10]  <= '0;
                            end
                        end
                        score     <= score_next;
                        combo     <= combo_next;
                        hit_pulse <= |hit_vec;
                    end
                    if (frame_tick) begin
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            state    <= FETCH;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                            state    <= MOVE;
                        end
                    end
                end
                FETCH: begin
                    pend <= pend | press;
                    if (pat_req && pat_valid) begin
                        pat_lat <= pat_data;
                        pat_req <= 1'b0;
                        state   <= SPAWN;
                    end else begin
                        pat_req <= 1'b1;
                    end
                end
                SPAWN: begin
                    pend <= pend | press;
                    for (int i = 0; i < 5; i++) begin
                        if (pat_lat[i] && !note_active[i]) begin
                            note_active[i]     <= 1'b1;
                            note_y[10*i +: 10] <= '0;
                        end
                    end
                    state <= MOVE;
                end
                MOVE: begin
                    pend <= pend | press;
                    for (int i = 0; i < 5; i++) begin
                        if (note_active[i]) begin
                            if (miss_vec[i]) begin
                                note_active[i]     <= 1'b0;
                                note_y[10*i +: 10] <= '0;
                            end else begin
                                note_y[10*i +: 10] <= y_mv[i];
                            end
                        end
                    end
                    if (|miss_vec) begin
                        combo      <= '0;
                        miss_pulse <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
